// File: rtl/ctr_pkg.sv
// Shared counter package: default sizing and the load clamp helper.
// Used by syn_up_counter and later counter blocks.
package ctr_pkg;

  localparam int CTR_WIDTH = 3;
  localparam int CTR_MOD   = 8;

  // Loads beyond the last legal state park the counter on it.
  function automatic int clamp_load(input int d, input int mod);
    return (d > mod - 1) ? mod - 1 : d;
  endfunction

endpackage

// File: rtl/syn_up_counter_bit.sv
// Synchronous T flip-flop cell with parallel load.
// Reset beats load, load beats toggle.
module syn_up_counter_bit (
  input  logic clk,
  input  logic rst,
  input  logic t,
  input  logic ld,
  input  logic ld_val,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else if (ld) begin
      q <= ld_val;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/syn_up_counter.sv
// Synchronous modulo-MOD up counter with enable, load,
// cascade terminal count and sticky overflow.
module syn_up_counter
  import ctr_pkg::*;
#(
  parameter int WIDTH = CTR_WIDTH,
  parameter int MOD   = CTR_MOD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);

  logic             at_last;
  logic             wrap;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] ld_val;

  assign at_last = (Q == LAST);
  assign tc      = en && at_last;
  assign wrap    = tc && !load && !rst;
  assign ld_val  = WIDTH'(clamp_load(32'(d), MOD));

  // At the last state, toggling every set bit returns Q to zero.
  always_comb begin
    carry    = '0;
    carry[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      carry[i] = carry[i-1] & Q[i-1];
    end
    t = '0;
    for (int i = 0; i < WIDTH; i++) begin
      t[i] = en & (at_last ? Q[i] : carry[i]);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    syn_up_counter_bit u_bit (
      .clk    (clk),
      .rst    (rst),
      .t      (t[i]),
      .ld     (load),
      .ld_val (ld_val[i]),
      .q      (Q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (wrap) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_syn_up_counter.sv
// Directed bench for syn_up_counter: MOD=8 table, MOD=5,
// and a two-stage cascade built on the MOD=8 instance.
module tb_syn_up_counter;

  logic       clk = 1'b0;
  logic       rst8, en8, load8, clr8;
  logic [2:0] d8;
  logic [2:0] q8, qh;
  logic       tc8, ovf8, tch, ovfh;
  logic       rst5, en5, load5, clr5;
  logic [2:0] d5, q5;
  logic       tc5, ovf5;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  syn_up_counter #(.WIDTH(3), .MOD(8)) u8 (
    .clk(clk), .rst(rst8), .en(en8), .load(load8), .d(d8),
    .clr_ovf(clr8), .Q(q8), .tc(tc8), .ovf(ovf8)
  );

  syn_up_counter #(.WIDTH(3), .MOD(8)) uh (
    .clk(clk), .rst(rst8), .en(tc8), .load(1'b0), .d(3'd0),
    .clr_ovf(1'b0), .Q(qh), .tc(tch), .ovf(ovfh)
  );

  syn_up_counter #(.WIDTH(3), .MOD(5)) u5 (
    .clk(clk), .rst(rst5), .en(en5), .load(load5), .d(d5),
    .clr_ovf(clr5), .Q(q5), .tc(tc5), .ovf(ovf5)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic       load;
    logic [2:0] d;
    logic       clr;
    logic       tc;
    logic [2:0] q;
    logic       ovf;
  } vec_t;

  vec_t tbl[$];

  // tc is the value before the edge; q and ovf are after it.
  task automatic v(input int r, input int e, input int l, input int dd,
                   input int c, input int etc, input int eq, input int eo);
    vec_t x;
    x.rst = 1'(r); x.en = 1'(e); x.load = 1'(l); x.d = 3'(dd);
    x.clr = 1'(c); x.tc = 1'(etc); x.q = 3'(eq); x.ovf = 1'(eo);
    tbl.push_back(x);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic edge8(input int r, input int e, input int l,
                       input int dd, input int c);
    @(negedge clk);
    rst8 = 1'(r); en8 = 1'(e); load8 = 1'(l); d8 = 3'(dd); clr8 = 1'(c);
    @(posedge clk);
    #1;
  endtask

  task automatic edge5(input int r, input int e, input int l, input int dd);
    @(negedge clk);
    rst5 = 1'(r); en5 = 1'(e); load5 = 1'(l); d5 = 3'(dd); clr5 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst8 = 1'b1; en8 = 0; load8 = 0; d8 = 0; clr8 = 0;
    rst5 = 1'b1; en5 = 0; load5 = 0; d5 = 0; clr5 = 0;

    // reset hold, 5 idle cycles
    for (int i = 0; i < 5; i++) v(0, 0, 0, 0, 0, 0, 0, 0);
    // free count from 0
    v(0, 1, 0, 0, 0, 0, 1, 0);
    v(0, 1, 0, 0, 0, 0, 2, 0);
    v(0, 1, 0, 0, 0, 0, 3, 0);
    v(0, 1, 0, 0, 0, 0, 4, 0);
    v(0, 1, 0, 0, 0, 0, 5, 0);
    v(0, 1, 0, 0, 0, 0, 6, 0);
    v(0, 1, 0, 0, 0, 0, 7, 0);
    v(0, 1, 0, 0, 0, 1, 0, 1);
    v(0, 1, 0, 0, 0, 0, 1, 1);
    v(0, 1, 0, 0, 0, 0, 2, 1);
    // load priority over increment
    v(0, 0, 1, 3, 0, 0, 3, 1);
    v(0, 1, 1, 5, 0, 0, 5, 1);
    v(0, 1, 0, 0, 0, 0, 6, 1);
    v(0, 1, 0, 0, 0, 0, 7, 1);
    // wrap sets ovf even with clr_ovf, then clear
    v(0, 1, 0, 0, 1, 1, 0, 1);
    v(0, 0, 0, 0, 1, 0, 0, 0);
    // load at last state blocks the wrap but tc still shows
    v(0, 1, 1, 7, 0, 0, 7, 0);
    v(0, 1, 1, 7, 0, 1, 7, 0);
    v(0, 1, 0, 0, 0, 1, 0, 1);
    // reset overrides everything
    v(0, 1, 0, 0, 0, 0, 1, 1);
    v(1, 1, 1, 4, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      @(negedge clk);
      rst8 = tbl[i].rst; en8 = tbl[i].en; load8 = tbl[i].load;
      d8 = tbl[i].d; clr8 = tbl[i].clr;
      #1;
      chk($sformatf("tbl%0d_tc", i), int'(tc8), int'(tbl[i].tc));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_q", i), int'(q8), int'(tbl[i].q));
      chk($sformatf("tbl%0d_ovf", i), int'(ovf8), int'(tbl[i].ovf));
    end

    // modulus-5 sequence and clamped load
    edge5(0, 0, 0, 0);
    chk("m5_reset_q", int'(q5), 0);
    chk("m5_reset_tc", int'(tc5), 0);
    begin
      int exp5[6] = '{1, 2, 3, 4, 0, 1};
      int pre = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        en5 = 1'b1;
        #1;
        chk($sformatf("m5_tc%0d", i), int'(tc5), (pre == 4) ? 1 : 0);
        @(posedge clk);
        #1;
        chk($sformatf("m5_q%0d", i), int'(q5), exp5[i]);
        pre = exp5[i];
      end
    end
    chk("m5_ovf", int'(ovf5), 1);
    edge5(0, 1, 1, 6);
    chk("m5_clamp", int'(q5), 4);
    edge5(0, 0, 1, 7);
    chk("m5_clamp7", int'(q5), 4);
    edge5(0, 1, 0, 0);
    chk("m5_wrap", int'(q5), 0);

    // cascade: 20 enabled edges
    edge8(1, 0, 0, 0, 0);
    chk("cas_rst", int'({qh, q8}), 0);
    repeat (20) edge8(0, 1, 0, 0, 0);
    chk("cas_20", int'({qh, q8}), 20);
    chk("cas_20_hi", int'(qh), 2);
    chk("cas_20_lo", int'(q8), 4);

    // cascade: reset mid-count at 13
    edge8(1, 0, 0, 0, 0);
    repeat (13) edge8(0, 1, 0, 0, 0);
    chk("cas_13", int'({qh, q8}), 13);
    chk("cas_13_ovf_lo", int'(ovf8), 1);
    edge8(1, 1, 0, 0, 0);
    chk("cas_mid_rst", int'({qh, q8}), 0);
    chk("cas_mid_ovf_lo", int'(ovf8), 0);
    chk("cas_mid_ovf_hi", int'(ovfh), 0);
    chk("cas_mid_tc_hi", int'(tch), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
